// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: latches two operands and walks a single
// 1-bit full adder LSB-first, reporting sum, carry-out and signed overflow.

module full_adder (
    input  logic din_A,
    input  logic din_B,
    input  logic din_cin,
    output logic dout_sum,
    output logic dout_carry
);
    assign dout_sum   = din_A ^ din_B ^ din_cin;
    assign dout_carry = (din_A & din_B) | (din_cin & (din_A ^ din_B));
endmodule

module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_start,
    input  logic             din_sub,
    input  logic [WIDTH-1:0] din_A,
    input  logic [WIDTH-1:0] din_B,
    output logic             dout_busy,
    output logic             dout_done,
    output logic [WIDTH-1:0] dout_sum,
    output logic             dout_carry,
    output logic             dout_overflow
);
    localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_ovf_pend;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               w_sum;
    logic               w_cout;

    // Operand shift registers present the current bit at position 0.
    full_adder u_fa (
        .din_A      (r_a[0]),
        .din_B      (r_b[0]),
        .din_cin    (r_carry),
        .dout_sum   (w_sum),
        .dout_carry (w_cout)
    );

    // Outputs are registered off the state, so busy/done trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (r_state == S_RUN);
            case (r_state)
                S_IDLE: begin
                    if (din_start) begin
                        r_a     <= din_A;
                        r_b     <= din_B ^ {WIDTH{din_sub}};
                        r_carry <= din_sub;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_shift <= {w_sum, r_shift[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(WIDTH - 1)) begin
                        // carry into the MSB vs. carry out of it
                        r_ovf_pend <= r_carry ^ w_cout;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_sum   <= r_shift;
                    r_cout  <= r_carry;
                    r_ovf   <= r_ovf_pend;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dout_busy     = r_busy;
    assign dout_done     = r_done;
    assign dout_sum      = r_sum;
    assign dout_carry    = r_cout;
    assign dout_overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed and randomized checks of serial_addsub_ctrl against an arithmetic
// reference model.

module tb_serial_addsub_ctrl;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         din_start;
    logic         din_sub;
    logic [W-1:0] din_A;
    logic [W-1:0] din_B;
    logic         dout_busy;
    logic         dout_done;
    logic [W-1:0] dout_sum;
    logic         dout_carry;
    logic         dout_overflow;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] hold;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .din_start     (din_start),
        .din_sub       (din_sub),
        .din_A         (din_A),
        .din_B         (din_B),
        .dout_busy     (dout_busy),
        .dout_done     (dout_done),
        .dout_sum      (dout_sum),
        .dout_carry    (dout_carry),
        .dout_overflow (dout_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {carry, overflow, sum} from plain integer arithmetic
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        int ua, ub, us, sa, sb, sr;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = ua - ((ua >= (1 << (W - 1))) ? (1 << W) : 0);
        sb = ub - ((ub >= (1 << (W - 1))) ? (1 << W) : 0);
        us = sub ? (ua + ((1 << W) - 1 - ub) + 1) : (ua + ub);
        sr = sub ? (sa - sb) : (sa + sb);
        c  = (us >= (1 << W));
        o  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {c, o, W'(us)};
    endfunction

    function automatic logic [31:0] res_now();
        return 32'({dout_carry, dout_overflow, dout_sum});
    endfunction

    // One operation; glitch_at/rst_at name the cycle after acceptance to disturb (0 = none).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int glitch_at, input int rst_at, input string tag);
        logic [W+1:0] exp;
        int done_n, ndone, nbusy;
        exp    = ref_op(a, b, sub);
        done_n = 0;
        ndone  = 0;
        nbusy  = 0;
        @(negedge clk);
        din_A = a; din_B = b; din_sub = sub; din_start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            din_start = (n == glitch_at);
            rst       = (n == rst_at);
            if (n == glitch_at) begin
                din_A   = W'($urandom);
                din_B   = W'($urandom);
                din_sub = ~sub;
            end else if (n == 1) begin
                din_A   = ~a;
                din_B   = ~b;
                din_sub = ~sub;
            end
            @(posedge clk);
            #1;
            if (dout_busy) nbusy++;
            if (dout_done) begin
                ndone++;
                if (done_n == 0) done_n = n;
                if (rst_at == 0) chk({tag, "_result"}, res_now(), 32'(exp));
            end
            if (n == 2) chk({tag, "_hold"}, res_now(), 32'(hold));
            if (n == rst_at) begin
                chk({tag, "_rst_busy"}, 32'(dout_busy), 32'd0);
                chk({tag, "_rst_res"}, res_now(), 32'd0);
                hold = '0;
            end
        end
        rst = 1'b0;
        chk({tag, "_ndone"}, 32'(ndone), (rst_at != 0) ? 32'd0 : 32'd1);
        if (rst_at == 0) begin
            chk({tag, "_latency"}, 32'(done_n), 32'(W + 1));
            chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W));
            hold = exp;
        end
    endtask

    initial begin
        int ndone;
        logic [W+1:0] exp;
        rst = 1'b1; din_start = 1'b0; din_sub = 1'b0; din_A = '0; din_B = '0;
        hold = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(dout_busy), 32'd0);
        chk("reset_done", 32'(dout_done), 32'd0);
        chk("reset_res", res_now(), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 0, 0, "add_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, 0, 0, "add_ff_01");
        run_op(8'h7F, 8'h01, 1'b0, 0, 0, "add_7f_01");
        run_op(8'h05, 8'h07, 1'b1, 0, 0, "sub_05_07");
        run_op(8'h80, 8'h01, 1'b1, 0, 0, "sub_80_01");
        run_op(8'h21, 8'h43, 1'b0, 4, 0, "start_in_run");
        run_op(8'h5A, 8'h3C, 1'b0, 0, 5, "rst_in_run");
        run_op(8'h03, 8'h04, 1'b0, 0, 0, "add_after_rst");

        // start held high for three back-to-back operations
        exp   = ref_op(8'h12, 8'h34, 1'b1);
        ndone = 0;
        @(negedge clk);
        din_A = 8'h12; din_B = 8'h34; din_sub = 1'b1; din_start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            din_start = (n < 30);
            @(posedge clk);
            #1;
            if (dout_done) begin
                ndone++;
                chk("b2b_spacing", 32'(n), 32'((W + 1) + (W + 2) * (ndone - 1)));
                chk("b2b_result", res_now(), 32'(exp));
            end
        end
        chk("b2b_ndone", 32'(ndone), 32'd3);
        hold = exp;

        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            run_op(a, b, 1'b0, 0, 0, "rnd_add");
            run_op(a, b, 1'b1, 0, 0, "rnd_sub");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
